// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences one instruction per pass
// through the shared ALU, memory, IR, PC and register-file enables.
module multicycle_controller #(
    parameter int unsigned STATE_W      = 4,
    parameter bit          ILLEGAL_HALT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ImmSrc,
    output logic [3:0]         ALUControl,
    output logic               illegal,
    output logic               retire,
    output logic [STATE_W-1:0] state_dbg
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC,
        S_LUI, S_AUIPC, S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_AUIPC = 4'b1000;
    localparam logic [3:0] ALU_LUI   = 4'b1001;
    localparam logic [3:0] ALU_SLL   = 4'b1010;
    localparam logic [3:0] ALU_SRA   = 4'b1011;
    localparam logic [3:0] ALU_SRL   = 4'b1100;

    state_t state_q, state_n;

    // Register and immediate forms share one decode; only the register form honours sub.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                            input logic is_reg);
        case (f3)
            3'b000:  arith_op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_n;
    end

    assign state_dbg = state_q;

    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_STORE:         ImmSrc = 3'b001;
            OP_BRANCH:        ImmSrc = 3'b010;
            OP_JAL:           ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        state_n    = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_n   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_RTYPE:          state_n = S_EXECR;
                    OP_ITYPE:          state_n = S_EXECI;
                    OP_BRANCH:         state_n = S_BRANCH;
                    OP_JAL:            state_n = S_JAL;
                    OP_JALR:           state_n = S_JALR;
                    OP_LUI:            state_n = S_LUI;
                    OP_AUIPC:          state_n = S_AUIPC;
                    default: begin
                        illegal = 1'b1;
                        if (ILLEGAL_HALT) begin
                            state_n = S_HALT;
                        end else begin
                            retire  = 1'b1;
                            state_n = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_n = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = arith_op(funct3, funct7b5, 1'b1);
                state_n    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = arith_op(funct3, funct7b5, 1'b0);
                state_n    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                retire  = 1'b1;
                // slt/sltu report "less than" as a non-zero result, so Zero means not-less.
                case (funct3)
                    3'b000: begin ALUControl = ALU_SUB;  PCWrite = Zero;  end
                    3'b001: begin ALUControl = ALU_SUB;  PCWrite = !Zero; end
                    3'b100: begin ALUControl = ALU_SLT;  PCWrite = !Zero; end
                    3'b101: begin ALUControl = ALU_SLT;  PCWrite = Zero;  end
                    3'b110: begin ALUControl = ALU_SLTU; PCWrite = !Zero; end
                    3'b111: begin ALUControl = ALU_SLTU; PCWrite = Zero;  end
                    default: PCWrite = 1'b0;
                endcase
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_n = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_n = S_JALRPC;
            end
            S_JALRPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_n = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALU_LUI;
                state_n    = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_AUIPC;
                state_n    = S_ALUWB;
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
            retire   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream against a per-instruction control-sequence model,
// plus directed reset, branch-boundary and illegal-opcode scenarios.
module tb_multicycle_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic       d0_PCWrite, d0_AdrSrc, d0_MemWrite, d0_IRWrite, d0_RegWrite;
    logic [1:0] d0_ResultSrc, d0_ALUSrcA, d0_ALUSrcB;
    logic [2:0] d0_ImmSrc;
    logic [3:0] d0_ALUControl;
    logic       d0_illegal, d0_retire;
    logic [3:0] d0_state_dbg;

    logic       d1_PCWrite, d1_AdrSrc, d1_MemWrite, d1_IRWrite, d1_RegWrite;
    logic [1:0] d1_ResultSrc, d1_ALUSrcA, d1_ALUSrcB;
    logic [2:0] d1_ImmSrc;
    logic [3:0] d1_ALUControl;
    logic       d1_illegal, d1_retire;
    logic [3:0] d1_state_dbg;

    multicycle_controller #(.STATE_W(4), .ILLEGAL_HALT(1'b0)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(d0_PCWrite), .AdrSrc(d0_AdrSrc), .MemWrite(d0_MemWrite), .IRWrite(d0_IRWrite),
        .RegWrite(d0_RegWrite), .ResultSrc(d0_ResultSrc), .ALUSrcA(d0_ALUSrcA),
        .ALUSrcB(d0_ALUSrcB), .ImmSrc(d0_ImmSrc), .ALUControl(d0_ALUControl),
        .illegal(d0_illegal), .retire(d0_retire), .state_dbg(d0_state_dbg)
    );

    multicycle_controller #(.STATE_W(4), .ILLEGAL_HALT(1'b1)) dut_halt (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(d1_PCWrite), .AdrSrc(d1_AdrSrc), .MemWrite(d1_MemWrite), .IRWrite(d1_IRWrite),
        .RegWrite(d1_RegWrite), .ResultSrc(d1_ResultSrc), .ALUSrcA(d1_ALUSrcA),
        .ALUSrcB(d1_ALUSrcB), .ImmSrc(d1_ImmSrc), .ALUControl(d1_ALUControl),
        .illegal(d1_illegal), .retire(d1_retire), .state_dbg(d1_state_dbg)
    );

    typedef struct packed {
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb;
        logic [3:0] alu;
        logic       ill, ret;
    } ctl_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    ctl_t        exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic ctl_t obs0();
        return '{d0_PCWrite, d0_AdrSrc, d0_MemWrite, d0_IRWrite, d0_RegWrite, d0_ResultSrc,
                 d0_ALUSrcA, d0_ALUSrcB, d0_ALUControl, d0_illegal, d0_retire};
    endfunction

    function automatic logic [5:0] en1();
        return {d1_PCWrite, d1_MemWrite, d1_IRWrite, d1_RegWrite, d1_illegal, d1_retire};
    endfunction

    function automatic logic [5:0] en0();
        return {d0_PCWrite, d0_MemWrite, d0_IRWrite, d0_RegWrite, d0_illegal, d0_retire};
    endfunction

    function automatic ctl_t alu_step(input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [3:0] alu);
        ctl_t c = '0;
        c.sa = sa; c.sb = sb; c.alu = alu;
        return c;
    endfunction

    // RV32I arithmetic semantics mapped onto the ALU code table.
    function automatic logic [3:0] arith_code(input logic [2:0] f3, input logic f7, input bit is_r);
        logic [3:0] tbl [8];
        tbl = '{4'b0000, 4'b1010, 4'b0101, 4'b0110, 4'b0100, 4'b1100, 4'b0011, 4'b0010};
        if (f3 == 3'd0 && is_r && f7) return 4'b0001;
        if (f3 == 3'd5 && f7)         return 4'b1011;
        return tbl[f3];
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    // Expected per-cycle control vectors for one instruction on the skip-illegal controller.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        ctl_t c, wb;
        bit   lt, cond;
        exp_q.delete();
        c = alu_step(2'b00, 2'b10, 4'b0000); c.irw = 1; c.pcw = 1; c.rs = 2'b10;
        exp_q.push_back(c);
        c = alu_step(2'b01, 2'b01, 4'b0000);
        if (!is_legal(o)) begin c.ill = 1; c.ret = 1; end
        exp_q.push_back(c);
        wb = '0; wb.rw = 1; wb.ret = 1;
        case (o)
            7'b0000011, 7'b0100011: begin
                exp_q.push_back(alu_step(2'b10, 2'b01, 4'b0000));
                c = '0; c.adr = 1;
                if (o[5]) begin c.mw = 1; c.ret = 1; exp_q.push_back(c); end
                else begin
                    exp_q.push_back(c);
                    c = '0; c.rs = 2'b01; c.rw = 1; c.ret = 1; exp_q.push_back(c);
                end
            end
            7'b0110011: begin exp_q.push_back(alu_step(2'b10, 2'b00, arith_code(f3, f7, 1))); exp_q.push_back(wb); end
            7'b0010011: begin exp_q.push_back(alu_step(2'b10, 2'b01, arith_code(f3, f7, 0))); exp_q.push_back(wb); end
            7'b1100011: begin
                c = alu_step(2'b10, 2'b00, f3[2] ? (f3[1] ? 4'b0110 : 4'b0101) : 4'b0001);
                lt   = !z;
                cond = f3[2] ? lt : z;
                c.pcw = (f3[2:1] == 2'b01) ? 1'b0 : (cond ^ f3[0]);
                if (f3[2:1] == 2'b01) c.alu = 4'b0000;
                c.ret = 1;
                exp_q.push_back(c);
            end
            7'b1101111: begin
                c = alu_step(2'b01, 2'b10, 4'b0000); c.pcw = 1; exp_q.push_back(c); exp_q.push_back(wb);
            end
            7'b1100111: begin
                exp_q.push_back(alu_step(2'b10, 2'b01, 4'b0000));
                c = alu_step(2'b01, 2'b10, 4'b0000); c.pcw = 1; exp_q.push_back(c); exp_q.push_back(wb);
            end
            7'b0110111: begin exp_q.push_back(alu_step(2'b00, 2'b01, 4'b1001)); exp_q.push_back(wb); end
            7'b0010111: begin exp_q.push_back(alu_step(2'b01, 2'b01, 4'b1000)); exp_q.push_back(wb); end
            default: ;
        endcase
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        build(o, f3, f7, z);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        foreach (exp_q[i]) begin
            @(negedge clk);
            check($sformatf("ctl op=%b f3=%b step%0d", o, f3, i), 32'(obs0()), 32'(exp_q[i]));
            check("immsrc", 32'(d0_ImmSrc), 32'(imm_of(o)));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [6:0] legal_ops [9];
        logic [6:0] o;
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        reset = 1; op = '0; funct3 = '0; funct7b5 = 0; Zero = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_en", 32'(en0()), 32'd0);
            @(posedge clk); #1;
        end
        reset = 0;

        // Reset asserted on entry to MEMWRITE, held 3 cycles.
        build(7'b0100011, 3'b010, 0, 0);
        op = 7'b0100011; funct3 = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sw_pre", 32'(obs0()), 32'(exp_q[i]));
            @(posedge clk); #1;
        end
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_memwrite_en", 32'(en0()), 32'd0);
            @(posedge clk); #1;
        end
        reset = 0;
        run_instr(7'b0010011, 3'b000, 0, 0);

        run_instr(7'b0110011, 3'b101, 1, 0);
        run_instr(7'b0000011, 3'b010, 0, 0);
        run_instr(7'b1100011, 3'b101, 0, 0);
        run_instr(7'b1100011, 3'b101, 0, 1);
        run_instr(7'b1100011, 3'b010, 0, 1);
        run_instr(7'b1100111, 3'b000, 0, 0);
        run_instr(7'b1111111, 3'b000, 0, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do o = 7'($urandom); while (is_legal(o));
            end else begin
                o = legal_ops[$urandom_range(0, 8)];
            end
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom));
        end

        // Parking controller: illegal opcode halts until reset.
        reset = 1; @(posedge clk); #1; reset = 0;
        op = 7'b1111111; funct3 = '0; funct7b5 = 0; Zero = 0;
        @(negedge clk);
        check("halt_fetch_en", 32'(en1()), 32'b101000);
        @(posedge clk); #1;
        @(negedge clk);
        check("halt_decode_en", 32'(en1()), 32'b000010);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            op = legal_ops[$urandom_range(0, 8)]; Zero = 1'($urandom); funct3 = 3'($urandom);
            @(negedge clk);
            check("halt_parked_en", 32'(en1()), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1; @(posedge clk); #1; reset = 0;
        @(negedge clk);
        check("halt_exit_fetch", 32'({d1_IRWrite, d1_PCWrite, d1_ALUSrcB}), 32'b1110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
